// File: rtl/watch_timekeeper_pkg.sv
// Shared types and limits for the watch timekeeper: set-mode states and
// the wrap points of the seconds/minutes/hours counters.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_e;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    // Modulo increment for the 6-bit minute/second fields.
    function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max_v);
        return (v == max_v) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] max_v);
        return (v == max_v) ? 5'd0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/watch_timekeeper_tick_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for a slow or
// asynchronous level input; all flops clear on reset.
module tick_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    // NOTE: every flop is written with <= so all three stages sample the
    // values from before this clock edge and shift by exactly one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/watch_timekeeper.sv
// Watch timekeeper: turns divided-clock edges into 1 s steps of hh:mm:ss and
// provides a set mode for hours/minutes. Optional `TWELVE_HOUR_EN` maps the
// displayed hour to 1..12 with a PM flag.
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 5000,
    parameter int PRESC_W       = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       pm,
    output logic [1:0] mode,
    output logic       sec_pulse
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic tick_rise;

    mode_e              mode_q,  mode_n;
    logic [PRESC_W-1:0] presc_q, presc_n;
    logic [4:0]         hr_q,    hr_n;
    logic [5:0]         min_q,   min_n;
    logic [5:0]         sec_q,   sec_n;
    logic               pulse_q, pulse_n;

    tick_sync_edge u_tick_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tick_in),
        .rise  (tick_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= RUN;
            presc_q <= '0;
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            mode_q  <= mode_n;
            presc_q <= presc_n;
            hr_q    <= hr_n;
            min_q   <= min_n;
            sec_q   <= sec_n;
            pulse_q <= pulse_n;
        end
    end

    // NOTE: every output of this block gets its hold value first, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        mode_n  = mode_q;
        presc_n = presc_q;
        hr_n    = hr_q;
        min_n   = min_q;
        sec_n   = sec_q;
        pulse_n = 1'b0;

        case (mode_q)
            RUN: begin
                // The step is taken even when mode_btn leaves RUN this cycle.
                if (tick_rise) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_n = '0;
                        pulse_n = 1'b1;
                        sec_n   = inc_wrap6(sec_q, SEC_MAX);
                        if (sec_q == SEC_MAX) begin
                            min_n = inc_wrap6(min_q, MIN_MAX);
                            if (min_q == MIN_MAX) begin
                                hr_n = inc_wrap5(hr_q, HR_MAX);
                            end
                        end
                    end else begin
                        presc_n = presc_q + 1'b1;
                    end
                end
                if (mode_btn) begin
                    mode_n = SET_HR;
                end
            end
            SET_HR: begin
                if (mode_btn) begin
                    mode_n = SET_MIN;
                end else if (inc_btn) begin
                    hr_n = inc_wrap5(hr_q, HR_MAX);
                end
            end
            SET_MIN: begin
                if (mode_btn) begin
                    mode_n  = RUN;
                    sec_n   = '0;
                    presc_n = '0;
                end else if (inc_btn) begin
                    min_n = inc_wrap6(min_q, MIN_MAX);
                end
            end
            default: begin
                mode_n = RUN;
            end
        endcase
    end

    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign mode      = mode_q;
    assign sec_pulse = pulse_q;

`ifdef TWELVE_HOUR_EN
    always_comb begin
        if (hr_q == 5'd0) begin
            hours = 5'd12;
        end else if (hr_q > 5'd12) begin
            hours = hr_q - 5'd12;
        end else begin
            hours = hr_q;
        end
        pm = (hr_q >= 5'd12);
    end
`else
    assign hours = hr_q;
    assign pm    = 1'b0;
`endif

endmodule

// File: tb/tb_watch_timekeeper.sv
// Randomised bench for watch_timekeeper against a seconds-of-day reference
// model; works with or without TWELVE_HOUR_EN.
module tb_watch_timekeeper;

    localparam int TPS = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick_in  = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn  = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pm;
    logic [1:0] mode;
    logic       sec_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time as seconds since midnight, plus mode and prescale.
    int m_t      = 0;
    int m_mode   = 0;
    int m_presc  = 0;
    int m_pulses = 0;

    int obs_pulses = 0;
    int run_len    = 0;

    watch_timekeeper #(
        .TICKS_PER_SEC (TPS),
        .PRESC_W       (13)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .pm        (pm),
        .mode      (mode),
        .sec_pulse (sec_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_hours(input int t);
        int h;
        h = t / 3600;
`ifdef TWELVE_HOUR_EN
        return (h % 12 == 0) ? 12 : h % 12;
`else
        return h;
`endif
    endfunction

    function automatic int exp_pm(input int t);
`ifdef TWELVE_HOUR_EN
        return (t / 3600 >= 12) ? 1 : 0;
`else
        return (t < 0) ? 1 : 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".hours"},   hours,   exp_hours(m_t));
        check({tag, ".minutes"}, minutes, (m_t / 60) % 60);
        check({tag, ".seconds"}, seconds, m_t % 60);
        check({tag, ".pm"},      pm,      exp_pm(m_t));
        check({tag, ".mode"},    mode,    m_mode);
    endtask

    task automatic model_tick();
        if (m_mode == 0) begin
            m_presc++;
            if (m_presc == TPS) begin
                m_presc = 0;
                m_t     = (m_t + 1) % 86400;
                m_pulses++;
            end
        end
    endtask

    task automatic model_mode();
        if (m_mode == 2) begin
            m_t     = m_t - (m_t % 60);
            m_presc = 0;
        end
        m_mode = (m_mode + 1) % 3;
    endtask

    task automatic model_inc();
        int h;
        int mi;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        if (m_mode == 1)
            m_t = m_t + (((h + 1) % 24) - h) * 3600;
        else if (m_mode == 2)
            m_t = m_t + (((mi + 1) % 60) - mi) * 60;
    endtask

    task automatic do_tick();
        @(negedge clk) tick_in = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        model_tick();
    endtask

    // Checks that the update lands exactly on the third rising edge.
    task automatic tick_timed(input string tag);
        int before_t;
        int before_p;
        before_t = m_t;
        before_p = m_pulses;
        @(negedge clk) tick_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".early_sec"},   seconds,   before_t % 60);
        check({tag, ".early_pulse"}, sec_pulse, 0);
        @(posedge clk);
        #1;
        model_tick();
        check_all(tag);
        check({tag, ".pulse"}, sec_pulse, (m_pulses != before_p) ? 1 : 0);
        @(negedge clk) tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input logic mb, input logic ib);
        @(negedge clk);
        mode_btn = mb;
        inc_btn  = ib;
        @(negedge clk);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        if (mb)
            model_mode();
        else if (ib)
            model_inc();
    endtask

    task automatic set_time(input int h, input int mi);
        while (m_mode != 0) press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        while (m_t / 3600 != h) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        while ((m_t / 60) % 60 != mi) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sec_pulse) begin
                obs_pulses++;
                run_len++;
            end else begin
                if (run_len > 0) check("pulse_width", run_len, 1);
                run_len = 0;
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;

        repeat (3) @(negedge clk);
        check_all("in_reset");
        check("in_reset.pulse", sec_pulse, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");

        // Ten edges at two per second give five seconds.
        repeat (10) do_tick();
        check_all("ten_ticks");
        check("ten_ticks.pulses", obs_pulses, 5);

        do_tick();
        tick_timed("latency");

        // Midnight rollover from 23:59:58.
        set_time(23, 59);
        repeat (58 * TPS) do_tick();
        check_all("at_58");
        repeat (TPS - 1) do_tick();
        tick_timed("to_59");
        repeat (TPS - 1) do_tick();
        tick_timed("to_00");

        // Set-mode wraps; leave prescaler mid-count so its clearing is visible.
        do_tick();
        press(1'b1, 1'b0);
        repeat (25) press(1'b0, 1'b1);
        check_all("hr_wrap");
        press(1'b1, 1'b0);
        repeat (61) press(1'b0, 1'b1);
        check_all("min_wrap");
        press(1'b1, 1'b0);
        check_all("back_run");
        do_tick();
        check_all("presc_clr_a");
        do_tick();
        check_all("presc_clr_b");

        // Ticks are ignored outside RUN.
        press(1'b1, 1'b0);
        repeat (20) do_tick();
        check_all("set_hr_ticks");
        check("set_hr_ticks.pulses", obs_pulses, m_pulses);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check_all("resume");

        // mode_btn beats inc_btn.
        press(1'b1, 1'b1);
        check_all("mode_and_inc");
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                do_tick();
            else if (r < 8)
                press(1'b1, 1'b0);
            else if (r == 8)
                press(1'b0, 1'b1);
            else
                press(1'b1, 1'b1);
            check_all("rnd");
        end

        // Asynchronous reset mid-second at 10:20:30.
        set_time(10, 20);
        repeat (30 * TPS + 1) do_tick();
        check_all("at_102030");
        check("total_pulses", obs_pulses, m_pulses);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_t     = 0;
        m_mode  = 0;
        m_presc = 0;
        check_all("async_reset");
        check("async_reset.pulse", sec_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
